seq_multiplier_4bit: RTL
========================

# seq_multiplier_4bit

Sequential unsigned shift-add multiplier, the companion to our 4-bit combinational divider: it rebuilds a dividend from quotient and divisor, and serves as the multiply half of the small arithmetic set. One operand pair is accepted per start pulse and one partial product is added per clock. The result is presented with a one-cycle done strobe. Intended for low-area datapaths where a WIDTH-cycle latency is acceptable.

## Interface

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge of clk.
- multiplicand  input  WIDTH  unsigned operand A; sampled when start is accepted.
- multiplier  input  WIDTH  unsigned operand B; sampled when start is accepted.
- product  output  2*WIDTH  registered result A*B; holds its value between completions.
- busy  output  1  high while the iteration is in progress.
- done  output  1  one-cycle pulse marking the cycle in which a new product is valid.

## Operation

- States:
  - IDLE: reset state.
  - CALC: iterating.
  - DONE: one cycle, presenting the result.
- Accept:
  - start=1 at a rising edge while in IDLE or DONE latches both operands.
  - On acceptance: accumulator cleared to 0, iteration counter cleared to 0, state goes to CALC.
- CALC, per edge:
  - If the multiplier register LSB=1, add the multiplicand (zero-extended to 2*WIDTH, shifted left by the counter value) to the accumulator.
  - Shift the multiplier register right by 1.
  - Increment the counter.
  - The edge that completes iteration WIDTH-1 writes the accumulator to product and moves to DONE.
- DONE:
  - done=1, busy=0.
  - Next edge: go to CALC if start=1 (back-to-back accept), else go to IDLE.
- Arithmetic:
  - Unsigned only.
  - Accumulator is 2*WIDTH bits; the maximum (2^WIDTH-1)^2 fits, so overflow is impossible and no carry-out is provided.
- Start in CALC is ignored. It is neither queued nor allowed to disturb the operands.
- Operands are not required to stay stable after acceptance.
- Zero operands still take the full WIDTH iterations; there is no early termination.
- product changes only at completion. It keeps the previous result throughout CALC.

## Timing

- Reset (rst_n=0, asynchronous, any time):
  - product=0, busy=0, done=0.
  - State IDLE, accumulator 0, counter 0.
  - Takes effect immediately without a clock.
- Reset deasserted mid-operation: the operation is lost. No done pulse follows, and product stays 0.
- Start accepted at edge E:
  - busy=1 from after E through edge E+WIDTH-1.
  - After edge E+WIDTH: product valid, done=1, busy=0.
  - Latency from the accepting edge to done is WIDTH cycles (4 for the default).
- done is high for exactly one cycle unless a back-to-back accept in DONE leads to another completion WIDTH cycles later.
- Maximum throughput is one result per WIDTH+1 cycles.
- busy and done are never high simultaneously.

## Test plan

- Reset, then start with A=8, B=2 -> busy high for 4 cycles, then done pulse with product=0x10, then IDLE.
- A=15, B=15 -> product=0xE1 (225) four cycles after accept; product holds 0xE1 afterwards until the next completion.
- A=0, B=9 and then A=9, B=0 -> each completes in exactly 4 cycles with product=0x00.
- Accept A=6, B=2, then pulse start with A=3, B=3 two cycles later -> second request ignored, product=0x0C, single done pulse.
- Accept A=13, B=7, assert rst_n=0 after 2 cycles -> outputs go to 0 immediately; after release no done pulse appears and product=0.
- Hold start=1 with A=12, B=6 then A=10, B=6 -> done pulses with product=0x48, then 5 cycles later product=0x3C. Compare every result against a reference A*B over a sweep of all 256 operand pairs.

Source files
------------

// File: rtl/seq_multiplier_4bit.sv
// Sequential unsigned shift-add multiplier.
// Takes one operand pair per accepted start, adds one partial product per
// clock over WIDTH iterations, then shows the result with a one-cycle done
// strobe. The product register holds the last result between completions.
//
// Handshake: start is sampled on each rising edge. It is accepted only in
// IDLE or DONE, and acceptance latches both operands. In CALC, start is
// ignored: it is neither queued nor allowed to disturb the latched operands.
// busy is high in CALC. done is high for the single DONE cycle. busy and
// done are never high together.
module seq_multiplier_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;     // multiplicand, zero-extended
    logic [WIDTH-1:0] mplier_q, mplier_d;  // multiplier, shifted right per step
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;

    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_sum;
    logic            last_iter;
    logic            accept;

    // Partial product for this iteration and the running sum it produces.
    // The sum cannot overflow because (2^WIDTH-1)^2 fits in PW bits.
    always_comb begin
        addend    = mplier_q[0] ? (mcand_q << cnt_q) : '0;
        acc_sum   = acc_q + addend;
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    // A new request is taken only when no iteration is in flight.
    always_comb begin
        accept = start && ((state_q == IDLE) || (state_q == DONE));
    end

    // Next state and datapath. Every iteration runs, even for zero operands.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    product_d = acc_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = accept ? CALC : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand capture overrides whatever the state case chose.
        if (accept) begin
            mcand_d  = {{WIDTH{1'b0}}, multiplicand};
            mplier_d = multiplier;
            acc_d    = '0;
            cnt_d    = '0;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Status comes straight from the state register, so it is glitch-free.
    always_comb begin
        product = product_q;
        busy    = (state_q == CALC);
        done    = (state_q == DONE);
        state_o = state_q;
    end

endmodule
